// File: rtl/output_rr_arbiter_if.sv
// output_rr_arbiter_if
//   Bundles the divider-result inputs, the downstream handshake and the
//   per-requester status flags of the output round-robin arbiter.
//   master : arbiter side (drives Done, results, ack/pending/overrun)
//   slave  : environment side (drives done_i, divider results, ready)
//   Signals:
//     done0/done1                 one-cycle result-valid pulses from cores
//     quotient0/1, remainder0/1   divider results, valid with done_i
//     ready_for_input             downstream wrapper can accept a result
//     Done                        one-cycle result-valid pulse downstream
//     quotient_16b, remainder_16b registered result to the wrapper
//     ack0/ack1                   pulse when that requester is issued
//     pending0/pending1           requester holds an unissued result
//     overrun0/overrun1           sticky: unissued result overwritten
interface output_rr_arbiter_if #(
    parameter int DATA_W = 16
);
    logic              done0;
    logic              done1;
    logic [DATA_W-1:0] quotient0;
    logic [DATA_W-1:0] remainder0;
    logic [DATA_W-1:0] quotient1;
    logic [DATA_W-1:0] remainder1;
    logic              ready_for_input;
    logic              Done;
    logic [DATA_W-1:0] quotient_16b;
    logic [DATA_W-1:0] remainder_16b;
    logic              ack0;
    logic              ack1;
    logic              pending0;
    logic              pending1;
    logic              overrun0;
    logic              overrun1;

    modport master (
        input  done0, done1, quotient0, remainder0, quotient1, remainder1,
        input  ready_for_input,
        output Done, quotient_16b, remainder_16b,
        output ack0, ack1, pending0, pending1, overrun0, overrun1
    );

    modport slave (
        output done0, done1, quotient0, remainder0, quotient1, remainder1,
        output ready_for_input,
        input  Done, quotient_16b, remainder_16b,
        input  ack0, ack1, pending0, pending1, overrun0, overrun1
    );
endinterface

// File: rtl/output_rr_arbiter.sv
// output_rr_arbiter
//   Collects results from two divider cores into per-requester hold
//   registers and issues them one at a time to a downstream output
//   wrapper, arbitrating round-robin when both hold a result.
//   Ports:
//     clk  : clock, all state on rising edge
//     rst  : asynchronous active-high reset
//     bus  : output_rr_arbiter_if.master (results in, handshake and
//            status flags out)
module output_rr_arbiter #(
    parameter int DATA_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    output_rr_arbiter_if.master  bus
);
    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        ISSUE       = 2'd1,
        WAIT_ACCEPT = 2'd2
    } state_t;

    state_t state, state_next;

    logic [2*DATA_W-1:0] hold [2];
    logic [2*DATA_W-1:0] data_in [2];
    logic [1:0]          done_vec;
    logic [1:0]          pending;
    logic [1:0]          overrun;
    logic [1:0]          take;
    logic                last_grant;
    logic                issued_id;
    logic                grant;
    logic                start;
    logic [DATA_W-1:0]   q_out;
    logic [DATA_W-1:0]   r_out;

    assign done_vec   = {bus.done1, bus.done0};
    assign data_in[0] = {bus.quotient0, bus.remainder0};
    assign data_in[1] = {bus.quotient1, bus.remainder1};

    // With both pending, the requester not granted last wins; otherwise
    // whichever one is pending (grant is a don't-care when neither is).
    assign grant = (pending[0] & pending[1]) ? ~last_grant : pending[1];
    assign start = (state == IDLE) && bus.ready_for_input && (|pending);
    assign take  = {start & grant, start & ~grant};

    always_comb begin
        state_next = state;
        case (state)
            IDLE:        if (start) state_next = ISSUE;
            ISSUE:       state_next = WAIT_ACCEPT;
            WAIT_ACCEPT: if (!bus.ready_for_input) state_next = IDLE;
            default:     state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            issued_id  <= 1'b0;
            q_out      <= '0;
            r_out      <= '0;
        end else begin
            state <= state_next;
            if (start) begin
                last_grant     <= grant;
                issued_id      <= grant;
                {q_out, r_out} <= hold[grant];
            end
        end
    end

    // A capture on the same edge that grants the requester keeps it
    // pending with the new data (old data is being issued, nothing lost).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                hold[i] <= '0;
            end
            pending <= '0;
            overrun <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (done_vec[i]) begin
                    hold[i]    <= data_in[i];
                    pending[i] <= 1'b1;
                    if (pending[i] && !take[i]) begin
                        overrun[i] <= 1'b1;
                    end
                end else if (take[i]) begin
                    pending[i] <= 1'b0;
                end
            end
        end
    end

    assign bus.Done          = (state == ISSUE);
    assign bus.ack0          = (state == ISSUE) && !issued_id;
    assign bus.ack1          = (state == ISSUE) && issued_id;
    assign bus.quotient_16b  = q_out;
    assign bus.remainder_16b = r_out;
    assign bus.pending0      = pending[0];
    assign bus.pending1      = pending[1];
    assign bus.overrun0      = overrun[0];
    assign bus.overrun1      = overrun[1];
endmodule
